// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples sclk/mosi/ss_n in the clk domain and returns a
// byte on miso from a one-entry holding buffer, for all four CPOL/CPHA modes.
module spi_slave_responder #(
   parameter int                DATA_W      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] TX_DEFAULT  = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun,
   output logic              abort
);
   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       ACTIVE   = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, ss_sync_reg;
   logic                   sclk_d_reg, ss_d_reg;

   logic [0:0]        state_reg;
   logic [DATA_W-1:0] tx_shift_reg, rx_shift_reg, buf_reg, rx_data_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic              buf_full_reg, reload_pending_reg;
   logic              miso_reg, miso_oe_reg, rx_valid_reg, underrun_reg, abort_reg;

   logic sclk_s, mosi_s, ss_s;
   logic sclk_rise, sclk_fall, ss_fall, ss_rise;
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   logic wr_en, frame_done, frame_start;
   logic [DATA_W-1:0] start_word;
   logic [DATA_W-1:0] rx_word;

   // ss_n synchronizer resets to the deselected level so reset release is not a select
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync_reg <= '0;
         mosi_sync_reg <= '0;
         ss_sync_reg   <= '1;
         sclk_d_reg    <= 1'b0;
         ss_d_reg      <= 1'b1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
         ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_n};
         sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
         ss_d_reg      <= ss_sync_reg[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
   assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;
   assign ss_fall   = ~ss_s & ss_d_reg;
   assign ss_rise   = ss_s & ~ss_d_reg;

   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   assign wr_en       = tx_valid & ~buf_full_reg;
   assign frame_done  = (state_reg == ACTIVE) && !ss_rise && sample_edge && (bit_cnt_reg == LAST_BIT);
   assign frame_start = ((state_reg == IDLE) && ss_fall) || frame_done;
   assign start_word  = buf_full_reg ? buf_reg : TX_DEFAULT;
   assign rx_word     = {rx_shift_reg[DATA_W-2:0], mosi_s};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg          <= IDLE;
         tx_shift_reg       <= '0;
         rx_shift_reg       <= '0;
         buf_reg            <= '0;
         buf_full_reg       <= 1'b0;
         bit_cnt_reg        <= '0;
         reload_pending_reg <= 1'b0;
         miso_reg           <= 1'b0;
         miso_oe_reg        <= 1'b0;
         rx_data_reg        <= '0;
         rx_valid_reg       <= 1'b0;
         underrun_reg       <= 1'b0;
         abort_reg          <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         underrun_reg <= 1'b0;
         abort_reg    <= 1'b0;

         // a write landing on a frame start refills the buffer for the next frame
         if (wr_en)
            buf_reg <= tx_data;
         if (frame_start)
            buf_full_reg <= wr_en;
         else if (wr_en)
            buf_full_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               miso_oe_reg <= 1'b0;
               if (ss_fall)
                  state_reg <= ACTIVE;
            end
            default: begin
               if (ss_rise) begin
                  state_reg          <= IDLE;
                  miso_oe_reg        <= 1'b0;
                  miso_reg           <= 1'b0;
                  bit_cnt_reg        <= '0;
                  reload_pending_reg <= 1'b0;
                  if (bit_cnt_reg != '0)
                     abort_reg <= 1'b1;
               end else begin
                  if (sample_edge) begin
                     rx_shift_reg <= rx_word;
                     if (bit_cnt_reg == LAST_BIT) begin
                        rx_data_reg  <= rx_word;
                        rx_valid_reg <= 1'b1;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
                  if (shift_edge) begin
                     if (CPHA) begin
                        miso_reg     <= tx_shift_reg[DATA_W-1];
                        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                     end else if (reload_pending_reg) begin
                        miso_reg           <= tx_shift_reg[DATA_W-1];
                        reload_pending_reg <= 1'b0;
                     end else begin
                        miso_reg     <= tx_shift_reg[DATA_W-2];
                        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                     end
                  end
               end
            end
         endcase

         // for CPHA=0 a wrap keeps the last bit on miso until the next trailing edge
         if (frame_start) begin
            tx_shift_reg <= start_word;
            underrun_reg <= ~buf_full_reg;
            bit_cnt_reg  <= '0;
            miso_oe_reg  <= 1'b1;
            if (!CPHA) begin
               if (state_reg == IDLE)
                  miso_reg <= start_word[DATA_W-1];
               else
                  reload_pending_reg <= 1'b1;
            end
         end
      end
   end

   assign miso     = miso_reg;
   assign miso_oe  = miso_oe_reg;
   assign tx_ready = ~buf_full_reg;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign underrun = underrun_reg;
   assign abort    = abort_reg;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a behavioural SPI master drives frames from a
// vector table, hand-written corner sequences and random frames.
module tb_spi_slave_responder;
   localparam int         HALF   = 6;
   localparam logic [7:0] TX_DEF = 8'h00;

   logic       clk, reset_n, cpol, cpha, sclk, ss_n, mosi;
   logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, underrun, abort;
   logic [7:0] tx_data, rx_data;

   int checks   = 0;
   int failures = 0;

   int         rxv_cnt = 0, und_cnt = 0, abort_cnt = 0, miso_bad_cnt = 0;
   logic [7:0] rx_log[$];
   logic       sclk_q = 1'b0, miso_q = 1'b0, last_lead = 1'b0;
   logic [7:0] last_rx;

   typedef struct {
      logic       cpol, cpha, load;
      logic [7:0] txb, mob, exp_mi, exp_rx;
      int         exp_und;
   } vec_t;

   spi_slave_responder dut (
      .clk(clk), .reset_n(reset_n), .CPOL(cpol), .CPHA(cpha),
      .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .abort(abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strobe counters and a record of which sclk edge preceded each miso change
   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt <= rxv_cnt + 1;
         rx_log.push_back(rx_data);
      end
      if (underrun) und_cnt <= und_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
      if (sclk != sclk_q) last_lead <= (sclk != cpol);
      if (cpha && !ss_n && (miso !== miso_q) && !last_lead) miso_bad_cnt <= miso_bad_cnt + 1;
      sclk_q <= sclk;
      miso_q <= miso;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] b);
      tx_valid = 1'b1;
      tx_data  = b;
      wait_clk(1);
      tx_valid = 1'b0;
      check("load_tx_ready_low", tx_ready, 1'b0);
   endtask

   // master: bit nbits-1 of mo goes first; mi collects what the master samples
   task automatic spi_xfer(input int nbits, input logic [31:0] mo, input bit keep_ss,
                           output logic [31:0] mi, output int und_at_start, output logic oe_ok);
      mi    = '0;
      oe_ok = 1'b1;
      ss_n  = 1'b0;
      if (!cpha) mosi = mo[nbits-1];
      wait_clk(HALF);
      und_at_start = und_cnt;
      for (int i = nbits - 1; i >= 0; i--) begin
         sclk = ~cpol;
         if (cpha) mosi = mo[i];
         else      mi[i] = miso;
         oe_ok = oe_ok & miso_oe;
         wait_clk(HALF);
         sclk = cpol;
         if (cpha)       mi[i] = miso;
         else if (i > 0) mosi = mo[i-1];
         wait_clk(HALF);
      end
      if (!keep_ss) begin
         ss_n = 1'b1;
         wait_clk(HALF);
      end
   endtask

   task automatic set_mode(input logic cp, input logic ch);
      cpol = cp;
      cpha = ch;
      sclk = cp;
      wait_clk(8);
   endtask

   // the wrap after the last bit is itself a frame start, so an empty buffer
   // there adds one more underrun pulse
   task automatic run_frame(input string tag, input logic cp, input logic ch, input logic load,
                            input logic [7:0] txb, input logic [7:0] mob,
                            input logic [7:0] exp_mi, input logic [7:0] exp_rx, input int exp_und);
      int u0, r0, a0, b0, us;
      logic [31:0] mi;
      logic oe_ok;
      set_mode(cp, ch);
      check({tag, "_oe_idle"}, miso_oe, 1'b0);
      if (load) load_tx(txb);
      u0 = und_cnt; r0 = rxv_cnt; a0 = abort_cnt; b0 = miso_bad_cnt;
      spi_xfer(8, {24'h0, mob}, 1'b0, mi, us, oe_ok);
      wait_clk(4);
      $display("frame %s mode=%0d%0d tx=%h mosi=%h -> miso=%h rx=%h", tag, cp, ch, txb, mob, mi[7:0], rx_data);
      check({tag, "_miso"}, mi[7:0], exp_mi);
      check({tag, "_rx_cnt"}, rxv_cnt - r0, 1);
      check({tag, "_rx_data"}, rx_data, exp_rx);
      check({tag, "_und_start"}, us - u0, exp_und);
      check({tag, "_und_total"}, und_cnt - u0, exp_und + 1);
      check({tag, "_abort"}, abort_cnt - a0, 0);
      check({tag, "_tx_ready"}, tx_ready, 1'b1);
      check({tag, "_oe_active"}, oe_ok, 1'b1);
      check({tag, "_oe_end"}, miso_oe, 1'b0);
      if (ch) check({tag, "_miso_edge"}, miso_bad_cnt - b0, 0);
      last_rx = exp_rx;
   endtask

   initial begin
      vec_t        vecs[5];
      logic [31:0] mi;
      int          us, u0, r0, a0, base;
      logic        oe_ok;
      logic        rcp, rch, rload;
      logic [7:0]  rtx, rmo;

      vecs[0] = '{1'b0, 1'b0, 1'b1, 8'b01001011, 8'b00110110, 8'b01001011, 8'b00110110, 0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 8'b10110100, 8'hA5,       8'b10110100, 8'hA5,       0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 8'b01001110, 8'h3C,       8'b01001110, 8'h3C,       0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 8'b01001110, 8'h3C,       8'b01001110, 8'h3C,       0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 8'hEE,       8'h96,       TX_DEF,      8'h96,       1};

      reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; last_rx = 8'h00;
      wait_clk(3);
      check("rst_miso", miso, 1'b0);
      check("rst_miso_oe", miso_oe, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_underrun", underrun, 1'b0);
      check("rst_abort", abort, 1'b0);
      reset_n = 1'b1;
      wait_clk(4);

      for (int v = 0; v < 5; v++)
         run_frame($sformatf("vec%0d", v), vecs[v].cpol, vecs[v].cpha, vecs[v].load,
                   vecs[v].txb, vecs[v].mob, vecs[v].exp_mi, vecs[v].exp_rx, vecs[v].exp_und);

      // write while the buffer is full is dropped
      set_mode(1'b0, 1'b0);
      load_tx(8'h5C);
      tx_valid = 1'b1; tx_data = 8'hE7;
      wait_clk(1);
      tx_valid = 1'b0;
      run_frame("ignored_wr", 1'b0, 1'b0, 1'b0, 8'h5C, 8'h19, 8'h5C, 8'h19, 0);

      // back-to-back frames with a refill during the first byte
      set_mode(1'b0, 1'b0);
      load_tx(8'h11);
      u0 = und_cnt; r0 = rxv_cnt; base = rx_log.size();
      fork
         spi_xfer(16, 32'h0000C35A, 1'b0, mi, us, oe_ok);
         begin : refill
            int k;
            k = 0;
            wait_clk(1);
            while (!tx_ready && k < 100) begin
               wait_clk(1);
               k++;
            end
            check("b2b_refill_ready", tx_ready, 1'b1);
            load_tx(8'h22);
         end
      join
      wait_clk(4);
      $display("frame b2b miso=%h rx_count=%0d", mi[15:0], rxv_cnt - r0);
      check("b2b_miso", mi[15:0], 16'h1122);
      check("b2b_rx_cnt", rxv_cnt - r0, 2);
      check("b2b_rx0", (rx_log.size() > base) ? rx_log[base] : 8'hxx, 8'hC3);
      check("b2b_rx1", (rx_log.size() > base + 1) ? rx_log[base+1] : 8'hxx, 8'h5A);
      check("b2b_und_start", us - u0, 0);
      check("b2b_und_total", und_cnt - u0, 1);

      // write coinciding with the frame start is held for the following frame
      set_mode(1'b0, 1'b0);
      check("hold_tx_ready_pre", tx_ready, 1'b1);
      u0 = und_cnt; r0 = rxv_cnt;
      fork
         spi_xfer(16, 32'h00000FF0, 1'b0, mi, us, oe_ok);
         begin
            wait_clk(2);
            tx_valid = 1'b1; tx_data = 8'h6D;
            wait_clk(1);
            tx_valid = 1'b0;
         end
      join
      wait_clk(4);
      $display("frame hold miso=%h rx=%h", mi[15:0], rx_data);
      check("hold_miso", mi[15:0], 16'h006D);
      check("hold_und_start", us - u0, 1);
      check("hold_und_total", und_cnt - u0, 2);
      check("hold_rx_data", rx_data, 8'hF0);
      last_rx = 8'hF0;

      // ss_n rises after 5 bits
      set_mode(1'b0, 1'b1);
      load_tx(8'h9A);
      r0 = rxv_cnt; a0 = abort_cnt;
      spi_xfer(5, 32'h00000015, 1'b0, mi, us, oe_ok);
      wait_clk(4);
      $display("frame abort miso=%h aborts=%0d", mi[4:0], abort_cnt - a0);
      check("abort_miso", mi[4:0], 5'b10011);
      check("abort_cnt", abort_cnt - a0, 1);
      check("abort_no_rx_valid", rxv_cnt - r0, 0);
      check("abort_rx_kept", rx_data, last_rx);
      check("abort_oe", miso_oe, 1'b0);
      check("abort_miso_idle", miso, 1'b0);

      // reset_n low after 3 bits of a mode-0 frame
      set_mode(1'b0, 1'b0);
      load_tx(8'h55);
      r0 = rxv_cnt; a0 = abort_cnt; u0 = und_cnt;
      spi_xfer(3, 32'h00000005, 1'b1, mi, us, oe_ok);
      check("rst_mid_pre_oe", miso_oe, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_miso", miso, 1'b0);
      check("rst_mid_oe", miso_oe, 1'b0);
      check("rst_mid_tx_ready", tx_ready, 1'b1);
      check("rst_mid_rx_data", rx_data, 8'h00);
      check("rst_mid_strobes", {rx_valid, underrun, abort}, 3'b000);
      wait_clk(3);
      ss_n = 1'b1;
      wait_clk(4);
      reset_n = 1'b1;
      wait_clk(4);
      check("rst_mid_no_strobe", (rxv_cnt - r0) + (abort_cnt - a0) + (und_cnt - u0), 0);
      run_frame("post_rst", 1'b0, 1'b0, 1'b1, 8'h81, 8'hFF, 8'h81, 8'hFF, 0);

      // random frames against the master-side model
      for (int n = 0; n < 16; n++) begin
         rcp   = 1'($urandom_range(0, 1));
         rch   = 1'($urandom_range(0, 1));
         rload = ($urandom_range(0, 3) != 0);
         rtx   = 8'($urandom);
         rmo   = 8'($urandom);
         run_frame($sformatf("rnd%0d", n), rcp, rch, rload, rtx, rmo,
                   rload ? rtx : TX_DEF, rmo, rload ? 0 : 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave-side responder, the receiving end of the SPI_Protocol master.
- Samples the externally supplied SCLK, MOSI and SS_n in the system clock domain and supports all four CPOL/CPHA modes.
- Returns a byte on MISO from a one-entry transmit holding buffer.
- Hands each received byte to local logic through a single-cycle valid strobe.

Parameters:
- DATA_W, 8: bits per SPI frame; MSB first.
- SYNC_STAGES, 2: synchronizer flops on sclk, mosi and ss_n (minimum 2).
- TX_DEFAULT, 8'h00: byte shifted out when the holding buffer is empty at frame start.

Ports:
- clk  input  1  system clock; every flop is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- CPOL  input  1  SCLK idle level; static while ss_n is low.
- CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; static while ss_n is low.
- sclk  input  1  SPI clock from master; asynchronous to clk.
- ss_n  input  1  active-low slave select from master address decode.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- miso_oe  output  1  MISO output enable; high only while selected.
- tx_data  input  DATA_W  byte to return to the master.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding buffer empty.
- rx_data  output  DATA_W  last complete received byte.
- rx_valid  output  1  one-clk strobe: rx_data updated.
- underrun  output  1  one-clk strobe: frame started with an empty buffer.
- abort  output  1  one-clk strobe: ss_n rose mid-frame.

Behaviour:
- Reset values (async, reset_n=0):
  - miso=0, miso_oe=0, tx_ready=1.
  - rx_data=0, rx_valid=0, underrun=0, abort=0.
  - State IDLE; shift registers, bit counter and holding buffer cleared.
- Input conditioning:
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops.
  - Edge detection uses one further flop, so an external edge is acted on SYNC_STAGES+1 clk later.
  - Required ratio: SCLK period >= 8 clk periods, with each phase >= 4 clk.
- Edge definitions:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Trailing edge = the opposite edge.
- Holding buffer:
  - tx_valid && tx_ready writes tx_data and drops tx_ready on the next clk.
  - tx_valid while tx_ready=0 is ignored.
  - The buffer is consumed (tx_ready=1 next clk) at each frame start.
- State IDLE:
  - miso_oe=0.
  - Synchronized ss_n falling goes to ACTIVE and performs a frame start.
- Frame start:
  - tx_shift is loaded from the buffer, or from TX_DEFAULT with a 1-clk underrun pulse if the buffer is empty.
  - bit_cnt=0, miso_oe=1.
  - If CPHA=0, miso = tx_shift MSB immediately, before the first edge.
- State ACTIVE, CPHA=0:
  - Leading edge: rx_shift = {rx_shift[DATA_W-2:0], mosi}; bit_cnt+1.
  - Trailing edge: tx_shift shifts left; miso = new MSB.
- State ACTIVE, CPHA=1:
  - Leading edge: miso = tx_shift MSB, then tx_shift shifts left.
  - Trailing edge: sample mosi; bit_cnt+1.
- Frame completion:
  - When the DATA_W-th sample is taken, rx_data is loaded and rx_valid pulses on the following clk.
  - bit_cnt wraps to 0 and a new frame start occurs in the same clk, giving back-to-back frames while ss_n stays low.
  - For CPHA=0 the new MSB is driven on the subsequent trailing edge instead of the usual shift.
- ss_n rising:
  - Go to IDLE; miso_oe=0, miso=0.
  - If 0 < bit_cnt < DATA_W: pulse abort; rx_data unchanged; no rx_valid.
  - If bit_cnt==0 (frame boundary): no abort.
- Sample coinciding with ss_n rising in the same clk: ss_n takes priority and the sample is discarded.
- A buffer write in the same clk as a frame start is not consumed by that frame; it is held for the next one.
- An edge while in IDLE is ignored.
- reset_n low mid-frame clears everything; no strobe is emitted.

Test Plan:
1. Mode 0 (CPOL=0, CPHA=0):
   - Stimulus: buffer 8'b01001011; master sends 8'b00110110; ss_n low for 8 SCLK cycles.
   - Required: master receives 01001011; rx_data=00110110; exactly one rx_valid; tx_ready=1 after frame start; no underrun.
2. Mode 1 (CPOL=0, CPHA=1):
   - Stimulus: buffer 8'b10110100; master sends 8'hA5.
   - Required: MISO bits change only on rising SCLK; master gets 10110100; rx_data=8'hA5.
3. Modes 2 and 3 (CPOL=1):
   - Stimulus: buffer 8'b01001110; master sends 8'h3C in each mode.
   - Required: rx_data=8'h3C and master gets 01001110 in both modes; miso_oe=0 before ss_n falls.
4. Back-to-back frames:
   - Stimulus: ss_n held low for 16 SCLK; buffer holds 8'h11, refilled with 8'h22 mid-frame; master sends 8'hC3 then 8'h5A.
   - Required: rx_valid with 8'hC3, then with 8'h5A; master gets 8'h11 then 8'h22.
5. Underrun and abort:
   - Stimulus: empty buffer, frame started -> underrun pulse, MISO returns 8'h00.
   - Stimulus: ss_n rises after 5 bits -> abort pulse; rx_data keeps its previous value; no rx_valid.
6. Reset mid-frame:
   - Stimulus: reset_n low after 3 bits.
   - Required: all outputs at reset values within the same cycle; a following full mode-0 frame (master 8'hFF, buffer 8'h81) completes correctly.
